// File: rtl/traffic_pkg.sv
// Shared types for the traffic phase scheduler.
// Phase encoding, cfg_sel codes and saturating add.
package traffic_pkg;

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    S0     = 3'd1,
    S1     = 3'd2,
    S2     = 3'd3,
    S3     = 3'd4,
    FLASH  = 3'd5
  } phase_e;

  localparam logic [1:0] CFG_G1 = 2'd0;
  localparam logic [1:0] CFG_G2 = 2'd1;
  localparam logic [1:0] CFG_Y  = 2'd2;
  localparam logic [1:0] CFG_AR = 2'd3;

  // a+b clamped to 2^w-1; w up to 16
  function automatic logic [15:0] sat_add(
    input logic [15:0] a,
    input logic [15:0] b,
    input int unsigned w
  );
    logic [16:0] s;
    logic [16:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (17'd1 << w) - 17'd1;
    return (s > mx) ? mx[15:0] : s[15:0];
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Tick-enabled loadable down counter with pedestrian clamp.
// Ports: clk, rs_n, load/value, tick, trunc/trunc_val -> cnt, zero.
module phase_timer #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rs_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         tick,
  input  logic         trunc,
  input  logic [W-1:0] trunc_val,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] dec;

  assign zero = (cnt == '0);
  assign dec  = (tick && !zero) ? cnt - W'(1) : cnt;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= value;
    end else if (trunc) begin
      // clamp applies on top of a coincident tick
      cnt <= (dec < trunc_val) ? dec : trunc_val;
    end else begin
      cnt <= dec;
    end
  end

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road phase scheduler; optional TRAFFIC_NIGHT_FLASH_EN adds night/FLASH.
// Ports: tick, cfg_*, ped_req -> lamps X/V/D, remain1/2, phase, ped_pend.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int G1_DEF  = 15,
  parameter int G2_DEF  = 15,
  parameter int Y_DEF   = 5,
  parameter int AR_DEF  = 2,
  parameter int PED_MAX = 4
) (
  input  logic             clk,
  input  logic             rs_n,
  input  logic             tick,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic             night,
`endif
  output logic             X1,
  output logic             V1,
  output logic             D1,
  output logic             X2,
  output logic             V2,
  output logic             D2,
  output logic [CNT_W-1:0] remain1,
  output logic [CNT_W-1:0] remain2,
  output logic [2:0]       phase,
  output logic             ped_pend
);

  localparam logic [CNT_W-1:0] PED_M1 = CNT_W'(PED_MAX - 1);
  localparam logic [CNT_W-1:0] AR_RST =
    (AR_DEF > 0) ? CNT_W'(AR_DEF - 1) : '0;

  // a stored 0 behaves as a 1-tick duration
  function automatic logic [CNT_W-1:0] dm1(
    input logic [CNT_W-1:0] d
  );
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] g1_q, g2_q, y_q, ar_q;
  phase_e           state_q, state_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] cnt;
  logic             zero;
  logic             adv;
  logic             trunc;
  logic             enter_s2;
  logic             ped_q;
  logic [CNT_W-1:0] y_eff;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] plus;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      g1_q <= CNT_W'(G1_DEF);
      g2_q <= CNT_W'(G2_DEF);
      y_q  <= CNT_W'(Y_DEF);
      ar_q <= CNT_W'(AR_DEF);
    end else if (cfg_we) begin
      unique case (cfg_sel)
        CFG_G1: g1_q <= cfg_data;
        CFG_G2: g2_q <= cfg_data;
        CFG_Y:  y_q  <= cfg_data;
        CFG_AR: ar_q <= cfg_data;
      endcase
    end
  end

  assign adv = tick & zero;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) state_q <= ALLRED;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    unique case (state_q)
      ALLRED: if (adv) begin
        state_d = S0; load = 1'b1; load_val = dm1(g1_q);
      end
      S0: if (adv) begin
        state_d = S1; load = 1'b1; load_val = dm1(y_q);
      end
      S1: if (adv) begin
        state_d = S2; load = 1'b1; load_val = dm1(g2_q);
      end
      S2: if (adv) begin
        state_d = S3; load = 1'b1; load_val = dm1(y_q);
      end
      S3: if (adv) begin
        state_d = S0; load = 1'b1; load_val = dm1(g1_q);
      end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      FLASH: if (tick && !night) begin
        state_d = ALLRED; load = 1'b1; load_val = dm1(ar_q);
      end
`endif
      default: begin
        state_d = ALLRED; load = 1'b1; load_val = dm1(ar_q);
      end
    endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (night && tick && state_q != FLASH) begin
      state_d  = FLASH;
      load     = 1'b1;
      load_val = '0;
    end
`endif
  end

  // request in the S2-entry cycle wins over the clear
  assign enter_s2 = (state_d == S2) && (state_q != S2);

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) ped_q <= 1'b0;
    else       ped_q <= ped_req | (ped_q & ~enter_s2);
  end

  // once clamped, cnt <= PED_M1 so it fires once per S0 visit
  assign trunc = (state_q == S0) && ped_q && (cnt > PED_M1);

  phase_timer #(
    .W       (CNT_W),
    .RST_VAL (AR_RST)
  ) u_timer (
    .clk       (clk),
    .rs_n      (rs_n),
    .load      (load),
    .value     (load_val),
    .tick      (tick),
    .trunc     (trunc),
    .trunc_val (PED_M1),
    .cnt       (cnt),
    .zero      (zero)
  );

`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic flash_q;
  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n)                 flash_q <= 1'b0;
    else if (state_q != FLASH) flash_q <= 1'b0;
    else if (tick)             flash_q <= ~flash_q;
  end
`endif

  always_comb begin
    {X1, V1, D1, X2, V2, D2} = 6'b000000;
    unique case (state_q)
      S0: {X1, D2} = 2'b11;
      S1: {V1, D2} = 2'b11;
      S2: {D1, X2} = 2'b11;
      S3: {D1, V2} = 2'b11;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      FLASH: begin
        V1 = flash_q;
        V2 = flash_q;
      end
`endif
      default: {D1, D2} = 2'b11;
    endcase
  end

  assign y_eff = (y_q == '0) ? CNT_W'(1) : y_q;
  assign base  = CNT_W'(sat_add(16'(cnt), 16'd1, CNT_W));
  assign plus  = CNT_W'(sat_add(16'(base), 16'(y_eff), CNT_W));

  always_comb begin
    remain1 = base;
    remain2 = base;
    if (state_q == S2) remain1 = plus;
    if (state_q == S0) remain2 = plus;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (state_q == FLASH) begin
      remain1 = '0;
      remain2 = '0;
    end
`endif
  end

  assign phase    = state_q;
  assign ped_pend = ped_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched (default build).
// Checks lamps, phase, remain values and pedestrian logic.
module tb_traffic_phase_sched;

  logic       clk = 1'b0;
  logic       rs_n = 1'b0;
  logic       tick = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_data = 8'd0;
  logic       ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic       night = 1'b0;
`endif
  logic       X1, V1, D1, X2, V2, D2;
  logic [7:0] remain1, remain2;
  logic [2:0] phase;
  logic       ped_pend;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] L_AR = 6'b001001;
  localparam logic [5:0] L_S0 = 6'b100001;
  localparam logic [5:0] L_S1 = 6'b010001;
  localparam logic [5:0] L_S2 = 6'b001100;
  localparam logic [5:0] L_S3 = 6'b001010;

  always #5 clk = ~clk;

  traffic_phase_sched dut (
    .clk      (clk),
    .rs_n     (rs_n),
    .tick     (tick),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .ped_req  (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night    (night),
`endif
    .X1       (X1),
    .V1       (V1),
    .D1       (D1),
    .X2       (X2),
    .V2       (V2),
    .D2       (D2),
    .remain1  (remain1),
    .remain2  (remain2),
    .phase    (phase),
    .ped_pend (ped_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [2:0] ph,
                        input logic [5:0] lamps);
    chk({tag, "_phase"}, 32'(phase), 32'(ph));
    chk({tag, "_lamps"}, 32'({X1, V1, D1, X2, V2, D2}), 32'(lamps));
  endtask

  task automatic chk_r(input string tag, input int r1, input int r2);
    chk({tag, "_remain1"}, 32'(remain1), 32'(r1));
    chk({tag, "_remain2"}, 32'(remain2), 32'(r2));
  endtask

  // called at a negedge; returns at a negedge after n edges with tick
  task automatic tk(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic cfg(input logic [1:0] s, input logic [7:0] d,
                     input logic with_tick);
    cfg_we = 1'b1; cfg_sel = s; cfg_data = d; tick = with_tick;
    @(negedge clk);
    cfg_we = 1'b0; tick = 1'b0;
  endtask

  task automatic ped(input logic with_tick);
    ped_req = 1'b1; tick = with_tick;
    @(negedge clk);
    ped_req = 1'b0; tick = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_st("rst", 3'd0, L_AR);
    chk_r("rst", 2, 2);
    chk("rst_ped", 32'(ped_pend), 0);
    rs_n = 1'b1;
    idle();

    // full default cycle
    tk(1);  chk_st("ar1", 3'd0, L_AR); chk_r("ar1", 1, 1);
    tk(1);  chk_st("s0a", 3'd1, L_S0); chk_r("s0a", 15, 20);
    tk(14); chk_st("s0z", 3'd1, L_S0); chk_r("s0z", 1, 6);
    tk(1);  chk_st("s1a", 3'd2, L_S1); chk_r("s1a", 5, 5);
    tk(5);  chk_st("s2a", 3'd3, L_S2); chk_r("s2a", 20, 15);
    tk(15); chk_st("s3a", 3'd4, L_S3); chk_r("s3a", 5, 5);
    tk(5);  chk_st("s0b", 3'd1, L_S0); chk_r("s0b", 15, 20);

    // G1 write takes effect only at next load
    cfg(2'd0, 8'd8, 1'b0);
    chk_r("wr_run", 15, 20);
    tk(14); chk_st("g1old", 3'd1, L_S0);
    tk(1);  chk_st("g1old_end", 3'd2, L_S1);
    tk(25); chk_st("g1new", 3'd1, L_S0); chk_r("g1new", 8, 13);
    tk(7);  chk_st("g1new_z", 3'd1, L_S0);
    tk(1);  chk_st("g1new_end", 3'd2, L_S1);

    // zero duration acts as one tick
    cfg(2'd0, 8'd0, 1'b0);
    tk(25); chk_st("g1zero", 3'd1, L_S0); chk_r("g1zero", 1, 6);
    tk(1);  chk_st("g1zero_end", 3'd2, L_S1);

    // write coincident with load: old value used
    tk(20); chk_st("pre_coin", 3'd4, L_S3);
    tk(4);  chk_r("pre_coin", 1, 1);
    cfg(2'd0, 8'd15, 1'b1);
    chk_st("coin", 3'd1, L_S0); chk_r("coin", 1, 6);
    tk(1);  chk_st("coin_end", 3'd2, L_S1);
    tk(25); chk_st("g1back", 3'd1, L_S0); chk_r("g1back", 15, 20);

    // pedestrian truncation without tick
    tk(2);  chk_r("ped_pre", 13, 18);
    ped(1'b0);
    chk("ped_set", 32'(ped_pend), 1);
    chk_r("ped_set", 13, 18);
    idle(); chk_r("ped_trunc", 4, 9);
    tk(3);  chk_st("ped_s0z", 3'd1, L_S0); chk_r("ped_s0z", 1, 6);
    tk(1);  chk_st("ped_s1", 3'd2, L_S1);
    chk("ped_hold", 32'(ped_pend), 1);
    tk(5);  chk_st("ped_s2", 3'd3, L_S2);
    chk("ped_clr", 32'(ped_pend), 0);

    // truncation coincident with tick at cnt=10
    tk(20); chk_st("tt_s0", 3'd1, L_S0);
    tk(3);  chk_r("tt_pre", 12, 17);
    ped(1'b1); chk_r("tt_set", 11, 16);
    chk("tt_ped", 32'(ped_pend), 1);
    tk(1);  chk_r("tt_trunc", 4, 9);
    ped(1'b0); chk_r("tt_again", 4, 9);
    idle(); chk_r("tt_again2", 4, 9);
    tk(4);  chk_st("tt_s1", 3'd2, L_S1);

    // request on the S2-entry edge stays pending
    tk(4);  chk_r("s2e_pre", 1, 1);
    ped(1'b1);
    chk_st("s2e", 3'd3, L_S2); chk_r("s2e", 20, 15);
    chk("s2e_ped", 32'(ped_pend), 1);
    idle(); chk("s2e_ped2", 32'(ped_pend), 1);
    tk(20); chk_st("s2e_s0", 3'd1, L_S0); chk_r("s2e_s0", 15, 20);
    idle(); chk_r("s2e_trunc", 4, 9);
    tk(4);  chk_st("s2e_s1", 3'd2, L_S1);
    tk(5);  chk("s2e_clr", 32'(ped_pend), 0);

    // late request: no truncation
    tk(20); chk_st("late_s0", 3'd1, L_S0);
    tk(12); chk_r("late_pre", 3, 8);
    ped(1'b0); chk("late_ped", 32'(ped_pend), 1);
    idle(); chk_r("late_keep", 3, 8);
    tk(3);  chk_st("late_s1", 3'd2, L_S1);

    // asynchronous reset mid-S2
    tk(5);  chk_st("ar_s2", 3'd3, L_S2);
    tk(3);  chk_r("ar_s2", 17, 12);
    #2 rs_n = 1'b0;
    #1;
    chk_st("async", 3'd0, L_AR);
    chk_r("async", 2, 2);
    chk("async_ped", 32'(ped_pend), 0);
    @(negedge clk);
    rs_n = 1'b1;
    idle(); chk_st("rel", 3'd0, L_AR);
    tk(1);  chk_st("rel_t1", 3'd0, L_AR); chk_r("rel_t1", 1, 1);
    tk(1);  chk_st("rel_s0", 3'd1, L_S0); chk_r("rel_s0", 15, 20);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
